pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline control unit: the stall/flush side of the hazard logic that complements the forwarding unit. It consumes memory-handshake status, load-use conditions, branch resolution and halt from the five-stage datapath, and drives the PC enable plus per-latch enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB. It holds the only pipeline-global state: halt drain and the sticky halted condition.

## Interface
- CPUID, default 0: core index; no functional effect.
- DRAIN_CYCLES, default 2: cycles from halt observed in MEM until the pipeline is frozen; legal range 1..7.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  instruction memory returned valid data this cycle.
- dhit  in  1  data memory completed the MEM-stage access this cycle.
- dREN_out_3, dWEN_out_3  in  1 each  MEM-stage instruction reads / writes data memory.
- dREN_out_2  in  1  EX-stage instruction is a load.
- wsel_out_2  in  5 (regbits_t)  EX-stage destination register.
- rs_in_2, rt_in_2  in  5 (regbits_t)  source registers of the instruction in ID.
- branch_taken_3  in  1  MEM-stage branch/jump redirects the PC.
- halt_out_3  in  1  MEM-stage instruction is HALT.
- pc_en  out  1  PC register load enable.
- latch_en  out  4  enable; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
- flush  out  3  load a bubble when enabled; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM.
- halted  out  1  pipeline permanently stopped.

## Operation
- States: RUN, DRAIN, HALT. 3-bit drain counter.
- Outputs are Mealy (combinational from state and inputs). Only state and counters are registered.
- RUN evaluates a strict priority list; the first match wins:
  1. dmem wait, (dREN_out_3|dWEN_out_3)&!dhit: pc_en=0, latch_en=0000, flush=000.
  2. branch_taken_3: pc_en=1, latch_en=1111, flush=111.
  3. halt_out_3: pc_en=0, latch_en=1111, flush=111. Next state DRAIN, counter=DRAIN_CYCLES-1.
  4. load-use, dREN_out_2 & wsel_out_2!=0 & (wsel_out_2==rs_in_2 | wsel_out_2==rt_in_2): pc_en=0, latch_en=1110, flush=010.
  5. imem wait, !ihit: pc_en=0, latch_en=1111, flush=001.
  6. Otherwise: pc_en=1, latch_en=1111, flush=000.
- DRAIN:
  - Outputs: pc_en=0, latch_en=1111, flush=111.
  - Counter decrements each cycle. When it reads 0, the next state is HALT.
  - Inputs are ignored, so a branch or load-use in a drained slot has no effect.
- HALT: pc_en=0, latch_en=0000, flush=000, halted=1. Sticky until RST.
- A register-0 destination never causes a load-use stall.

## Timing
- Reset, sampled on a rising CLK:
  - state=RUN, counter=0, halted=0.
  - While RST is high, outputs are forced to pc_en=0, latch_en=0000, flush=000.
- Load-use costs exactly one cycle. The next cycle re-evaluates normally; the EX slot then holds a bubble, so the condition clears.
- Branch penalty: 3 slots flushed in the same cycle branch_taken_3 is seen. If dmem wait coincides, the flush is deferred: the latches hold, so branch_taken_3 persists until dhit.
- Halt to halted=1: DRAIN_CYCLES+1 rising edges after the cycle halt_out_3 is first seen with no dmem wait.
- RST mid-DRAIN or in HALT returns to RUN on that edge.

## Configuration
- PIPE_PERF_EN defined: adds outputs stall_cnt (32) and flush_cnt (32), both reset to 0 and saturating at 32'hFFFFFFFF.
  - stall_cnt increments on each RUN cycle with pc_en=0.
  - flush_cnt increments on each cycle the branch flush (priority 2) fires.
- PIPE_PERF_EN undefined: both ports and their registers are absent. Behaviour is otherwise identical.

## Structure
- cpu_types_pkg gains:
  - pipe_state_t enum {RUN, DRAIN, HALT}.
  - Latch index constants L_IFID=0, L_IDEX=1, L_EXMEM=2, L_MEMWB=3.
- A pipe_ctrl_if interface (modports pc for this block, tb for the bench) carries all non-clock ports.
- One sub-module, load_use_detect: purely combinational compare of dREN_out_2/wsel_out_2 against rs_in_2/rt_in_2, producing one stall bit.

## Test plan
- RST high 2 cycles, then low with ihit=1, no hazards -> during reset pc_en=0, latch_en=0000; afterwards pc_en=1, latch_en=1111, flush=000, halted=0.
- dREN_out_2=1, wsel_out_2=5, rt_in_2=5, ihit=1 -> one cycle of pc_en=0, latch_en=1110, flush=010; next cycle with dREN_out_2=0 -> normal. Repeat with wsel_out_2=0 -> no stall.
- dWEN_out_3=1, dhit=0 for 3 cycles with branch_taken_3=1 -> latch_en=0000 for 3 cycles; on dhit=1 -> pc_en=1, latch_en=1111, flush=111.
- ihit=0 with no other hazard -> pc_en=0, flush=001, latch_en=1111.
- halt_out_3 pulse with DRAIN_CYCLES=2 -> flush=111 for 3 cycles, then halted=1 with latch_en=0000 indefinitely; RST returns to RUN.
- With PIPE_PERF_EN: 4 stall cycles and 2 branch flushes -> stall_cnt=4, flush_cnt=2.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the five-stage core: register index type, pipeline control
// state encoding and pipeline-latch bit positions.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } pipe_state_t;

  localparam int unsigned L_IFID  = 0;
  localparam int unsigned L_IDEX  = 1;
  localparam int unsigned L_EXMEM = 2;
  localparam int unsigned L_MEMWB = 3;

  localparam int unsigned NUM_LATCHES = 4;
  localparam int unsigned NUM_FLUSHES = 3;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of every non-clock signal between the datapath and pipeline_ctrl.
// PIPE_PERF_EN adds the stall/flush performance counters.
interface pipe_ctrl_if;
  import cpu_types_pkg::*;

  logic       RST;
  logic       ihit;
  logic       dhit;
  logic       dREN_out_3;
  logic       dWEN_out_3;
  logic       dREN_out_2;
  regbits_t   wsel_out_2;
  regbits_t   rs_in_2;
  regbits_t   rt_in_2;
  logic       branch_taken_3;
  logic       halt_out_3;

  logic                   pc_en;
  logic [NUM_LATCHES-1:0] latch_en;
  logic [NUM_FLUSHES-1:0] flush;
  logic                   halted;
`ifdef PIPE_PERF_EN
  logic [31:0]            stall_cnt;
  logic [31:0]            flush_cnt;
`endif

  modport pc (
    input  RST, ihit, dhit, dREN_out_3, dWEN_out_3, dREN_out_2,
           wsel_out_2, rs_in_2, rt_in_2, branch_taken_3, halt_out_3,
`ifdef PIPE_PERF_EN
    output stall_cnt, flush_cnt,
`endif
    output pc_en, latch_en, flush, halted
  );

  modport tb (
    output RST, ihit, dhit, dREN_out_3, dWEN_out_3, dREN_out_2,
           wsel_out_2, rs_in_2, rt_in_2, branch_taken_3, halt_out_3,
`ifdef PIPE_PERF_EN
    input  stall_cnt, flush_cnt,
`endif
    input  pc_en, latch_en, flush, halted
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX writing a register that the instruction in ID reads.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     dren_i,
  input  regbits_t wsel_i,
  input  regbits_t rs_i,
  input  regbits_t rt_i,
  output logic     stall_o
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign stall_o = dren_i && (wsel_i != '0) && ((wsel_i == rs_i) || (wsel_i == rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline, including halt drain.
// Optional PIPE_PERF_EN adds saturating stall_cnt / flush_cnt counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUID        = 0,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic     CLK,
  pipe_ctrl_if.pc pcif
);

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  pipe_state_t            state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;

  logic                   load_use;
  logic                   dmem_wait;
  logic                   branch_fire;
  logic                   pc_en_c;
  logic [NUM_LATCHES-1:0] latch_c;
  logic [NUM_FLUSHES-1:0] flush_c;

  load_use_detect u_lud (
    .dren_i  (pcif.dREN_out_2),
    .wsel_i  (pcif.wsel_out_2),
    .rs_i    (pcif.rs_in_2),
    .rt_i    (pcif.rt_in_2),
    .stall_o (load_use)
  );

  assign dmem_wait = (pcif.dREN_out_3 || pcif.dWEN_out_3) && !pcif.dhit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en_c     = 1'b0;
    latch_c     = '0;
    flush_c     = '0;
    branch_fire = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_wait) begin
          pc_en_c = 1'b0;
        end else if (pcif.branch_taken_3) begin
          pc_en_c     = 1'b1;
          latch_c     = '1;
          flush_c     = '1;
          branch_fire = 1'b1;
        end else if (pcif.halt_out_3) begin
          latch_c = '1;
          flush_c = '1;
          state_d = DRAIN;
          cnt_d   = DRAIN_INIT;
        end else if (load_use) begin
          latch_c          = '1;
          latch_c[L_IFID]  = 1'b0;
          flush_c[L_IDEX]  = 1'b1;
        end else if (!pcif.ihit) begin
          latch_c         = '1;
          flush_c[L_IFID] = 1'b1;
        end else begin
          pc_en_c = 1'b1;
          latch_c = '1;
        end
      end
      DRAIN: begin
        latch_c = '1;
        flush_c = '1;
        if (cnt_q == '0) begin
          state_d = HALT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALT: begin
        pc_en_c = 1'b0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (pcif.RST) begin
      pc_en_c     = 1'b0;
      latch_c     = '0;
      flush_c     = '0;
      branch_fire = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (pcif.RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pcif.pc_en    = pc_en_c;
  assign pcif.latch_en = latch_c;
  assign pcif.flush    = flush_c;
  assign pcif.halted   = (state_q == HALT);

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        run_stall;

  assign run_stall = (state_q == RUN) && !pc_en_c;

  always_ff @(posedge CLK) begin
    if (pcif.RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (run_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (branch_fire && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign pcif.stall_cnt = stall_cnt_q;
  assign pcif.flush_cnt = flush_cnt_q;
`endif

endmodule
